cla_pipe_adder: RTL and testbench

Parametrised, two-stage pipelined carry-lookahead adder/subtractor with a valid/ready handshake. It generalises the team's fixed 16-bit group generate/propagate logic to any width that is a multiple of 4. It computes 4-bit group G/P in stage 1 and resolves lookahead carries, sum and flags in stage 2. It sits between the decode/operand-fetch stage and the ALU result mux, and also serves as the address adder.

---
 rtl/cla_pkg.sv | 27 ++
 rtl/cla_pipe_adder_if.sv | 46 ++++
 rtl/cla_group4.sv | 33 +++
 rtl/cla_pipe_adder.sv | 195 +++++++++++++++++++
 tb/tb_cla_pipe_adder.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the pipelined carry-lookahead adder/subtractor.
//   GRP_W          : width of one lookahead group (fixed at 4 bits)
//   gp_t           : group generate/propagate pair
//   stage_state_t  : occupancy state of one pipeline stage (EMPTY/FULL)
//   grp_count()    : number of lookahead groups for a given operand width
// -----------------------------------------------------------------------------
package cla_pkg;

  localparam int GRP_W = 4;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_t;

  function automatic int grp_count(input int width);
    return width / GRP_W;
  endfunction

endpackage

// File: rtl/cla_pipe_adder_if.sv
// -----------------------------------------------------------------------------
// cla_pipe_adder_if
// Operand/result handshake bundle for cla_pipe_adder.
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid and ready are both 1. Once valid is raised, the sender
// keeps valid and its payload unchanged until that transfer happens; ready
// may depend combinationally on the other channel and never gates valid.
//
// Signals:
//   in_valid/in_ready : operand channel (producer -> adder)
//   a, b, sub, cin    : operands, subtract select, carry-in (add only)
//   out_valid/out_ready : result channel (adder -> consumer)
//   sum, cout, ovfl, zero : result and flags
// Modports:
//   master : producer/consumer side (drives operands, accepts results)
//   slave  : the adder itself
// -----------------------------------------------------------------------------
interface cla_pipe_adder_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovfl;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovfl, zero
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovfl, zero
  );

endinterface

// File: rtl/cla_group4.sv
// -----------------------------------------------------------------------------
// cla_group4
// Combinational 4-bit lookahead group: per-bit generate/propagate plus the
// group generate/propagate used by the inter-group carry chain.
//
// Ports:
//   a     in  4 : operand A slice
//   b_eff in  4 : effective operand B slice (already inverted for subtract)
//   p     out 4 : per-bit propagate  a ^ b_eff
//   g     out 4 : per-bit generate   a & b_eff
//   gp    out   : group generate / propagate
// -----------------------------------------------------------------------------
module cla_group4
  import cla_pkg::*;
(
  input  logic [GRP_W-1:0] a,
  input  logic [GRP_W-1:0] b_eff,
  output logic [GRP_W-1:0] p,
  output logic [GRP_W-1:0] g,
  output gp_t              gp
);

  assign g = a & b_eff;
  assign p = a ^ b_eff;

  // Group generates if some bit generates and every bit above it propagates.
  assign gp.g = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
  assign gp.p = p[3] & p[2] & p[1] & p[0];

endmodule

// File: rtl/cla_pipe_adder.sv
// -----------------------------------------------------------------------------
// cla_pipe_adder
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow
// control on both sides. Stage 1 forms effective operands and 4-bit group
// generate/propagate; stage 2 resolves group carries, intra-group carries,
// the sum and the flags, and registers them onto the result channel.
//
// Parameters:
//   WIDTH : operand width, multiple of 4 and >= 4 (elaboration error otherwise)
// Ports:
//   clk      in  : rising-edge clock
//   rst      in  : synchronous active-high reset; discards in-flight work
//   bus      slave modport of cla_pipe_adder_if (operands in, result out)
//   s1_state out : occupancy of stage 1 (debug visibility)
//   s2_state out : occupancy of stage 2 (debug visibility)
//
// Optional build macro:
//   CLA_SAT_EN : when defined, an overflowing result is clamped to the most
//                positive / most negative value; zero is taken after clamping.
//                When undefined the wrapped result is emitted and no clamp
//                logic exists.
// -----------------------------------------------------------------------------
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  cla_pipe_adder_if.slave bus,
  output stage_state_t  s1_state,
  output stage_state_t  s2_state
);

  localparam int NG = grp_count(WIDTH);

  if ((WIDTH < GRP_W) || ((WIDTH % GRP_W) != 0)) begin : g_bad_width
    $error("cla_pipe_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  // ---------------------------------------------------------------------------
  // Handshake / stage advance
  // ---------------------------------------------------------------------------
  logic s1_valid;
  logic s2_valid;
  logic s1_adv;
  logic s2_adv;

  assign s1_valid = (s1_state == ST_FULL);
  assign s2_valid = (s2_state == ST_FULL);

  // A stage may take new contents when it is empty or its occupant moves on
  // in the same edge. The chain is combinational back to out_ready, which
  // keeps full throughput without a skid buffer.
  assign s2_adv       = !s2_valid || bus.out_ready;
  assign s1_adv       = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv;

  // ---------------------------------------------------------------------------
  // Stage 1 combinational: effective operand and group generate/propagate
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] b_eff_c;
  logic [WIDTH-1:0] p_c;
  logic [WIDTH-1:0] g_c;
  gp_t  [NG-1:0]    gp_c;
  logic             c0_c;

  assign b_eff_c = bus.sub ? ~bus.b : bus.b;
  assign c0_c    = bus.sub | bus.cin;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla_group4 u_grp (
      .a     (bus.a  [k*GRP_W +: GRP_W]),
      .b_eff (b_eff_c[k*GRP_W +: GRP_W]),
      .p     (p_c    [k*GRP_W +: GRP_W]),
      .g     (g_c    [k*GRP_W +: GRP_W]),
      .gp    (gp_c[k])
    );
  end

  // ---------------------------------------------------------------------------
  // Stage 1 registers. The operand pair is carried as per-bit p/g, which is
  // all stage 2 needs for the sum; only the two operand MSBs are kept as-is
  // for the overflow rule and the clamp direction.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] s1_p;
  logic [WIDTH-1:0] s1_g;
  gp_t  [NG-1:0]    s1_gp;
  logic             s1_c0;
  logic             s1_a_msb;
  logic             s1_b_eff_msb;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_state     <= ST_EMPTY;
      s1_p         <= '0;
      s1_g         <= '0;
      s1_gp        <= '0;
      s1_c0        <= 1'b0;
      s1_a_msb     <= 1'b0;
      s1_b_eff_msb <= 1'b0;
    end else begin
      unique case (s1_state)
        ST_EMPTY: if (bus.in_valid)            s1_state <= ST_FULL;
        ST_FULL:  if (s2_adv && !bus.in_valid) s1_state <= ST_EMPTY;
        default:                               s1_state <= ST_EMPTY;
      endcase
      if (s1_adv && bus.in_valid) begin
        s1_p         <= p_c;
        s1_g         <= g_c;
        s1_gp        <= gp_c;
        s1_c0        <= c0_c;
        s1_a_msb     <= bus.a[WIDTH-1];
        s1_b_eff_msb <= b_eff_c[WIDTH-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 combinational: lookahead carries, sum, flags
  // ---------------------------------------------------------------------------
  logic [NG:0]      grp_c;
  logic [WIDTH-1:0] raw_sum;
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;
  logic             ovfl_c;
  logic             zero_c;

  // Inter-group chain: each group's carry-in comes from the group below.
  always_comb begin
    grp_c    = '0;
    grp_c[0] = s1_c0;
    for (int k = 0; k < NG; k++) begin
      grp_c[k+1] = s1_gp[k].g | (s1_gp[k].p & grp_c[k]);
    end
  end

  // Intra-group carries only ripple across 4 bits, seeded by the group carry.
  always_comb begin
    logic c;
    c       = 1'b0;
    raw_sum = '0;
    for (int k = 0; k < NG; k++) begin
      c = grp_c[k];
      for (int j = 0; j < GRP_W; j++) begin
        raw_sum[k*GRP_W + j] = s1_p[k*GRP_W + j] ^ c;
        c = s1_g[k*GRP_W + j] | (s1_p[k*GRP_W + j] & c);
      end
    end
  end

  assign cout_c = grp_c[NG];
  assign ovfl_c = (s1_a_msb == s1_b_eff_msb) && (raw_sum[WIDTH-1] != s1_a_msb);

`ifdef CLA_SAT_EN
  // Overflow direction follows operand A's sign: positive operands can only
  // overflow upward, negative ones downward.
  assign sum_c = !ovfl_c  ? raw_sum :
                 s1_a_msb ? {1'b1, {(WIDTH-1){1'b0}}} :
                            {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign sum_c = raw_sum;
`endif

  assign zero_c = (sum_c == '0);

  // ---------------------------------------------------------------------------
  // Stage 2 registers drive the result channel directly, so the payload is
  // only rewritten when stage 2 is allowed to advance; it holds while stalled.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_state <= ST_EMPTY;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
      bus.ovfl <= 1'b0;
      bus.zero <= 1'b0;
    end else begin
      unique case (s2_state)
        ST_EMPTY: if (s1_valid)                   s2_state <= ST_FULL;
        ST_FULL:  if (bus.out_ready && !s1_valid) s2_state <= ST_EMPTY;
        default:                                  s2_state <= ST_EMPTY;
      endcase
      if (s2_adv && s1_valid) begin
        bus.sum  <= sum_c;
        bus.cout <= cout_c;
        bus.ovfl <= ovfl_c;
        bus.zero <= zero_c;
      end
    end
  end

  assign bus.out_valid = s2_valid;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_cla_pipe_adder
// Self-checking bench for cla_pipe_adder at WIDTH=16. The reference model is
// plain integer arithmetic on a +/- b; in-flight results are kept in an
// expected queue together with the edge at which each operand was accepted.
// -----------------------------------------------------------------------------
module tb_cla_pipe_adder;
  import cla_pkg::*;

  localparam int WIDTH = 16;
  localparam int W     = WIDTH + 3;   // {sum, cout, ovfl, zero}

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
  } op_t;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cla_pipe_adder_if #(.WIDTH(WIDTH)) bus ();
  stage_state_t s1_state;
  stage_state_t s2_state;

  cla_pipe_adder #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .s1_state (s1_state),
    .s2_state (s2_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int           acc_q[$];
  op_t          stim_q[$];
  int           tests_run = 0;
  int           tests_failed = 0;
  int           edge_cnt = 0;
  logic         stalled_prev = 1'b0;
  logic [W-1:0] prev_out = '0;
  int           drain_cnt = 0;
  int           first_drain = -1;
  int           last_drain = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: integer arithmetic, signed range test for overflow.
  function automatic logic [W-1:0] model(input op_t o);
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] s;
    int               sa;
    int               sb;
    int               res;
    logic             ov;
    sa = {{16{o.a[WIDTH-1]}}, o.a};
    sb = {{16{o.b[WIDTH-1]}}, o.b};
    if (o.sub) begin
      full = {1'b0, o.a} + {1'b0, ~o.b} + 17'd1;
      res  = sa - sb;
    end else begin
      full = {1'b0, o.a} + {1'b0, o.b} + {16'd0, o.cin};
      res  = sa + sb + int'(o.cin);
    end
    ov = (res > 32767) || (res < -32768);
    s  = full[WIDTH-1:0];
`ifdef CLA_SAT_EN
    if (ov) s = (res > 0) ? 16'h7FFF : 16'h8000;
`endif
    return {s, full[WIDTH], ov, (s == 16'h0000)};
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.a   = 16'($urandom_range(0, 16'hFFFF));
    o.b   = 16'($urandom_range(0, 16'hFFFF));
    o.sub = 1'($urandom_range(0, 1));
    o.cin = 1'($urandom_range(0, 1));
    return o;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one clock cycle. Presents the head of stim_q (if any), checks the
  // handshake and result against the scoreboard, then advances one edge.
  // ---------------------------------------------------------------------------
  task automatic run_cycle(input logic rdy);
    op_t          o;
    logic         have_op;
    logic         exp_rdy;
    logic         exp_vld;
    logic [W-1:0] cur;
    logic [W-1:0] e;
    have_op = (stim_q.size() > 0);
    o       = have_op ? stim_q[0] : rand_op();
    bus.in_valid  = have_op;
    bus.a         = o.a;
    bus.b         = o.b;
    bus.sub       = o.sub;
    bus.cin       = o.cin;
    bus.out_ready = rdy;
    #1;
    // Two results may be in flight; a third is only taken if one leaves.
    exp_rdy = (exp_q.size() < 2) || rdy;
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    exp_vld = 1'b0;
    if (exp_q.size() > 0) exp_vld = (edge_cnt >= acc_q[0] + 1);
    chk("out_valid", 32'(bus.out_valid), 32'(exp_vld));
    cur = {bus.sum, bus.cout, bus.ovfl, bus.zero};
    if (stalled_prev) chk("stall_hold", 32'(cur), 32'(prev_out));
    if (exp_vld && rdy) begin
      e = exp_q.pop_front();
      void'(acc_q.pop_front());
      chk("result", 32'(cur), 32'(e));
      drain_cnt++;
      if (first_drain < 0) first_drain = edge_cnt;
      last_drain = edge_cnt;
    end
    stalled_prev = exp_vld && !rdy;
    prev_out     = cur;
    if (have_op && exp_rdy) begin
      exp_q.push_back(model(o));
      acc_q.push_back(edge_cnt + 1);
      void'(stim_q.pop_front());
    end
    @(posedge clk);
    edge_cnt++;
    #1;
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (stim_q.size() == 0 && exp_q.size() == 0) break;
      run_cycle(1'b1);
    end
    chk("drain_pending_ops", 32'(stim_q.size()), 32'd0);
    chk("drain_pending_results", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic apply_reset(input int cycles);
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      edge_cnt++;
    end
    #1;
    rst = 1'b0;
    exp_q.delete();
    acc_q.delete();
    stim_q.delete();
    stalled_prev = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    chk({tag, "_sum"},       32'(bus.sum),       32'd0);
    chk({tag, "_cout"},      32'(bus.cout),      32'd0);
    chk({tag, "_ovfl"},      32'(bus.ovfl),      32'd0);
    chk({tag, "_zero"},      32'(bus.zero),      32'd0);
  endtask

  // One operation into an empty pipe; result checked against fixed values
  // two edges after acceptance, then drained through the scoreboard.
  task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic cin, input logic [15:0] x_sum,
                          input logic x_cout, input logic x_ovfl, input logic x_zero);
    op_t o;
    o.a = a; o.b = b; o.sub = sub; o.cin = cin;
    stim_q.push_back(o);
    run_cycle(1'b1);
    chk({tag, "_lat1_valid"}, 32'(bus.out_valid), 32'd0);
    run_cycle(1'b1);
    chk({tag, "_lat2_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_sum"},  32'(bus.sum),  32'(x_sum));
    chk({tag, "_cout"}, 32'(bus.cout), 32'(x_cout));
    chk({tag, "_ovfl"}, 32'(bus.ovfl), 32'(x_ovfl));
    chk({tag, "_zero"}, 32'(bus.zero), 32'(x_zero));
    drain(4);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    apply_reset(2);
    check_idle_outputs("reset");
    chk("reset_s2_state", 32'(s2_state), 32'(ST_EMPTY));

    // Directed arithmetic
    directed("add_cin",  16'h1234, 16'h0FFF, 1'b0, 1'b1, 16'h2234, 1'b0, 1'b0, 1'b0);
    directed("sub_zero", 16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
`ifdef CLA_SAT_EN
    directed("pos_ovfl", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    directed("neg_ovfl", 16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
`else
    directed("pos_ovfl", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    directed("neg_ovfl", 16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
`endif
    directed("wrap",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    directed("sub_min",  16'h0000, 16'h8000, 1'b1, 1'b1,
`ifdef CLA_SAT_EN
             16'h7FFF,
`else
             16'h8000,
`endif
             1'b0, 1'b1, 1'b0);

    // Backpressure: 4 back-to-back ops, consumer stalls 3 cycles from the
    // first valid result.
    drain_cnt = 0;
    for (int i = 0; i < 4; i++) stim_q.push_back(rand_op());
    run_cycle(1'b1);
    run_cycle(1'b1);
    run_cycle(1'b0);
    chk("bp_stall_in_ready_low", 32'(bus.in_ready), 32'd0);
    run_cycle(1'b0);
    run_cycle(1'b0);
    drain(20);
    chk("bp_result_count", 32'(drain_cnt), 32'd4);

    // Full-rate random streaming
    drain_cnt   = 0;
    first_drain = -1;
    last_drain  = -1;
    for (int i = 0; i < 100; i++) stim_q.push_back(rand_op());
    drain(300);
    chk("stream_count", 32'(drain_cnt), 32'd100);
    chk("stream_gapless", 32'(last_drain - first_drain), 32'd99);

    // Mid-flight reset: two ops accepted and held, then discarded.
    for (int i = 0; i < 2; i++) stim_q.push_back(rand_op());
    run_cycle(1'b0);
    run_cycle(1'b0);
    chk("mid_inflight_valid", 32'(bus.out_valid), 32'd1);
    apply_reset(1);
    check_idle_outputs("mid_reset");
    drain_cnt = 0;
    for (int i = 0; i < 6; i++) run_cycle(1'b1);
    chk("mid_reset_no_result", 32'(drain_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
